// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an M x N weight-stationary systolic array.
//
// A job optionally loads N weight columns, streams num_vec iact vectors into
// the array with a per-row skew, then waits for num_vec results to come back
// from the last array column before pulsing done.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i, num_vec_i        job request and vector count (sampled in idle)
//   reuse_w_i                 skip the weight load phase for this job
//   w_valid_i/w_ready_o       weight-column handshake, w_data_i[i] -> row i
//   in_valid_i/in_ready_o     iact-vector handshake, in_data_i unskewed
//   acc_valid_i               valid_out of array column N-1
//   ctrl_out_o                array ctrl (NOP=0, MAC=1)
//   iact_out_o                skewed iact, element i to array row i
//   wctrl_out_o, weights_out_o  weight-write enables and weight buses
//   busy_o, done_o            job active / one-cycle completion pulse

`ifndef B_WIDTH
`define B_WIDTH 8
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 2
`endif

module systolic_ctrl #(
    parameter int unsigned M   = 2,
    parameter int unsigned N   = 2,
    parameter int unsigned B_W = `B_WIDTH,
    parameter int unsigned CW  = `CTRL_WIDTH,
    parameter int unsigned KW  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [KW-1:0]                   num_vec_i,
    input  logic                            reuse_w_i,
    input  logic                            w_valid_i,
    output logic                            w_ready_o,
    input  logic [M-1:0][B_W-1:0]           w_data_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [M-1:0][B_W-1:0]           in_data_i,
    input  logic                            acc_valid_i,
    output logic [CW-1:0]                   ctrl_out_o,
    output logic [M-1:0][B_W-1:0]           iact_out_o,
    output logic [N-1:0][M-1:0]             wctrl_out_o,
    output logic [N-1:0][M-1:0][B_W-1:0]    weights_out_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned ColW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CtrlNop = '0;
    localparam logic [CW-1:0] CtrlMac = CW'(1);

    typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

    state_e                         state_q, state_d;
    logic [KW-1:0]                  num_vec_q, num_vec_d;
    logic [KW-1:0]                  vec_cnt_q, vec_cnt_d;
    logic [KW-1:0]                  res_cnt_q, res_cnt_d;
    logic [ColW-1:0]                col_q, col_d;
    logic [N-1:0][M-1:0]            wctrl_q;
    logic [N-1:0][M-1:0][B_W-1:0]   weights_q;
    logic [CW-1:0]                  ctrl_q;
    logic                           w_hs, in_hs, acc_hit;

    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        vec_cnt_d = vec_cnt_q;
        res_cnt_d = res_cnt_q;
        col_d     = col_q;

        w_ready_o  = (state_q == StLoadW);
        in_ready_o = (state_q == StStream) && (vec_cnt_q < num_vec_q);
        w_hs       = w_ready_o && w_valid_i;
        in_hs      = in_ready_o && in_valid_i;
        // Results past num_vec are dropped so the counter cannot run away or wrap.
        acc_hit    = acc_valid_i && ((state_q == StStream) || (state_q == StDrain)) &&
                     (res_cnt_q != num_vec_q);

        if (in_hs)   vec_cnt_d = vec_cnt_q + KW'(1);
        if (acc_hit) res_cnt_d = res_cnt_q + KW'(1);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    num_vec_d = num_vec_i;
                    vec_cnt_d = '0;
                    res_cnt_d = '0;
                    col_d     = '0;
                    state_d   = reuse_w_i ? StStream : StLoadW;
                end
            end
            StLoadW: begin
                if (w_hs) begin
                    if (col_q == ColW'(N - 1)) state_d = StStream;
                    else                       col_d   = col_q + ColW'(1);
                end
            end
            StStream: if (vec_cnt_d == num_vec_q) state_d = StDrain;
            StDrain:  if (res_cnt_d == num_vec_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            num_vec_q <= '0;
            vec_cnt_q <= '0;
            res_cnt_q <= '0;
            col_q     <= '0;
            wctrl_q   <= '0;
            weights_q <= '0;
            ctrl_q    <= CtrlNop;
        end else begin
            state_q   <= state_d;
            num_vec_q <= num_vec_d;
            vec_cnt_q <= vec_cnt_d;
            res_cnt_q <= res_cnt_d;
            col_q     <= col_d;
            // Write enables are single-cycle pulses; weights hold between loads.
            wctrl_q   <= '0;
            if (w_hs) begin
                wctrl_q[col_q]   <= '1;
                weights_q[col_q] <= w_data_i;
            end
            ctrl_q    <= in_hs ? CtrlMac : CtrlNop;
        end
    end

    // Row r delays its element by r+1 cycles; bubbles shift in as zero.
    for (genvar r = 0; r < M; r++) begin : g_skew
        logic [B_W-1:0] pipe_q [r+1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k <= r; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= in_hs ? in_data_i[r] : '0;
                for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end

        assign iact_out_o[r] = pipe_q[r];
    end

    assign ctrl_out_o    = ctrl_q;
    assign wctrl_out_o   = wctrl_q;
    assign weights_out_o = weights_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter M, default 2: array rows, which is also the iact vector length.
REQ-002 Parameter N, default 2: array columns.
REQ-003 Parameter B_W, default `B_WIDTH: iact and weight element width.
REQ-004 Parameter CW, default `CTRL_WIDTH: array ctrl width. Encodings: NOP=0, MAC=1.
REQ-005 Parameter KW, default 16: vector-count width.
REQ-006 clk  in  1  single clock; all flops rise on posedge clk.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 start  in  1  job request; sampled only in IDLE.
REQ-009 num_vec  in  KW  iact vectors in the job; sampled with start.
REQ-010 reuse_w  in  1  skip weight load for the job; sampled with start.
REQ-011 w_valid / w_ready  in / out  1 / 1  weight-column handshake.
REQ-012 w_data  in  M x B_W  one weight column, element i for row i.
REQ-013 in_valid / in_ready  in / out  1 / 1  iact-vector handshake.
REQ-014 in_data  in  M x B_W  one unskewed iact vector.
REQ-015 acc_valid  in  1  valid_out of array column N-1.
REQ-016 ctrl_out  out  CW  array ctrl input.
REQ-017 iact_out  out  M x B_W  skewed iact, driven to array row i.
REQ-018 wctrl_out  out  N x M  array weight-write enables.
REQ-019 weights_out  out  N x M x B_W  weight buses.
REQ-020 busy / done  out  1 / 1  job active / 1-cycle completion pulse.

Function
REQ-021 FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-022 IDLE to LOAD_W on start with reuse_w=0; IDLE to STREAM on start with reuse_w=1. num_vec is latched in either case.
REQ-023 LOAD_W: w_ready=1, column counter c starts at 0. Each w_valid&&w_ready handshake, registered:
  - wctrl_out[c][0..M-1]=1 for exactly one cycle;
  - weights_out[c][i]=w_data[i].
  After column N-1 is accepted, go to STREAM.
REQ-024 In LOAD_W, wctrl_out is all-zero in cycles without a handshake. wctrl_out is all-zero in every other state. weights_out holds its last value.
REQ-025 STREAM: in_ready=1 while the accepted count is below the latched num_vec. When the count reaches num_vec, go to DRAIN.
REQ-026 Skew: an accepted vector presents in_data[i] on iact_out[i] exactly i+1 cycles after the handshake. The same vector presents ctrl_out=MAC exactly 1 cycle after the handshake.
REQ-027 Bubble handling: a cycle with no accepted vector injects NOP on ctrl_out and zeros on the skew pipeline. Skew pipelines shift every cycle in every state.
REQ-028 A result counter increments on each acc_valid pulse in STREAM or DRAIN. acc_valid in any other state is ignored.
REQ-029 DRAIN to DONE when result count equals num_vec, including the cycle an equalizing pulse arrives.
REQ-030 num_vec=0: STREAM passes directly to DRAIN, then DONE. No MAC is issued.
REQ-031 DONE: done=1 for one cycle, then IDLE.
REQ-032 busy=1 in every state except IDLE.
REQ-033 start asserted while busy is ignored. It is not queued.
REQ-034 Vector and result counters are KW bits and never wrap within a job.

Reset
REQ-035 On rst low, asynchronously: state=IDLE and every counter=0.
REQ-036 On rst low, every output is 0, including ctrl_out=NOP, wctrl_out, weights_out, iact_out, and all skew and ctrl pipeline stages.
REQ-037 Reset mid-job abandons the job with no done pulse. First legal start is the cycle after rst deasserts.

Verification
REQ-038 Reset: hold rst=0 mid-STREAM -> all outputs 0 immediately. After release, busy=0.
REQ-039 M=N=2, reuse_w=0, num_vec=3, columns {1,2},{3,4} -> two single-cycle wctrl_out column pulses with matching weights_out. Then 3 MAC cycles. iact_out[1] lags iact_out[0] by 1 cycle. done after the 3rd acc_valid.
REQ-040 reuse_w=1, num_vec=2 -> w_ready never asserted, wctrl_out stays 0, STREAM entered the cycle after start.
REQ-041 in_valid toggled 1,0,1 -> ctrl_out reads MAC,NOP,MAC. iact_out is zero in the bubble slot on each row at its skewed time.
REQ-042 num_vec=0 -> done exactly 3 cycles after start (STREAM, DRAIN, DONE). No MAC is issued.
REQ-043 start pulsed during DRAIN, and acc_valid pulsed while IDLE -> neither has any effect. Exactly one done pulse per accepted job.
